// File: rtl/cosim_trace_pkg.sv
// Shared record type and field widths for the cosim commit-trace path.
package cosim_trace_pkg;

  localparam int unsigned XLEN   = 64;
  localparam int unsigned INSN_W = 32;
  localparam int unsigned PRIV_W = 3;

  typedef struct packed {
    logic              commit;
    logic              exception;
    logic              interrupt;
    logic [XLEN-1:0]   iaddr;
    logic [INSN_W-1:0] insn;
    logic [XLEN-1:0]   cause;
    logic              has_wdata;
    logic [XLEN-1:0]   wdata;
    logic [PRIV_W-1:0] priv;
  } trace_rec_t;

endpackage

// File: rtl/cosim_trace_fifo.sv
// Circular record buffer: compacting multi-lane push, up to two pops per cycle.
// Always drains min(2, occupancy); the caller guarantees free space before pushing.
module cosim_trace_fifo
  import cosim_trace_pkg::*;
#(
  parameter int unsigned IN_WIDTH = 4,
  parameter int unsigned DEPTH    = 16
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     push_en_i,
  input  logic [IN_WIDTH-1:0]      push_valid_i,
  input  trace_rec_t               push_rec_i [IN_WIDTH],
  output trace_rec_t               pop_rec_o [2],
  output logic [1:0]               pop_cnt_o,
  output logic [$clog2(DEPTH):0]   occupancy_o
);

  localparam int unsigned IDX_W = $clog2(DEPTH);
  localparam int unsigned PTR_W = IDX_W + 1;

  trace_rec_t       mem_q [DEPTH];
  logic [PTR_W-1:0] wr_q, wr_d;
  logic [PTR_W-1:0] rd_q, rd_d;
  logic [PTR_W-1:0] occ;
  logic [PTR_W-1:0] push_cnt;
  logic [PTR_W-1:0] rd_next;
  logic [IDX_W-1:0] widx [IN_WIDTH];

  // Each valid lane lands at wr + (number of valid lanes below it), closing holes.
  always_comb begin
    push_cnt = '0;
    for (int unsigned i = 0; i < IN_WIDTH; i++) begin
      widx[i] = IDX_W'(wr_q + push_cnt);
      if (push_valid_i[i]) push_cnt = push_cnt + PTR_W'(1);
    end
  end

  assign occ         = wr_q - rd_q;
  assign occupancy_o = occ;
  assign pop_cnt_o   = (occ >= PTR_W'(2)) ? 2'd2 : occ[1:0];
  assign rd_next     = rd_q + PTR_W'(1);

  assign pop_rec_o[0] = mem_q[rd_q[IDX_W-1:0]];
  assign pop_rec_o[1] = mem_q[rd_next[IDX_W-1:0]];

  always_comb begin
    wr_d = wr_q;
    if (push_en_i) wr_d = wr_q + push_cnt;
    rd_d = rd_q + PTR_W'(pop_cnt_o);
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
    end
  end

  always_ff @(posedge clock) begin
    for (int unsigned i = 0; i < IN_WIDTH; i++) begin
      if (push_en_i && push_valid_i[i]) mem_q[widx[i]] <= push_rec_i[i];
    end
  end

endmodule

// File: rtl/cosim_trace_packer.sv
// Producer end of the two-lane cosim commit trace: buffers retire records in program
// order and drains up to two per cycle onto registered trace lanes with a cycle stamp.
module cosim_trace_packer
  import cosim_trace_pkg::*;
#(
  parameter int unsigned IN_WIDTH = 4,
  parameter int unsigned DEPTH    = 16,
  parameter int unsigned XLEN     = 64   // must equal cosim_trace_pkg::XLEN
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic [IN_WIDTH-1:0]        in_valid,
  output logic                       in_ready,
  input  logic [IN_WIDTH-1:0]        in_commit,
  input  logic [IN_WIDTH-1:0]        in_exception,
  input  logic [IN_WIDTH-1:0]        in_interrupt,
  input  logic [IN_WIDTH*XLEN-1:0]   in_iaddr,
  input  logic [IN_WIDTH*32-1:0]     in_insn,
  input  logic [IN_WIDTH*XLEN-1:0]   in_cause,
  input  logic [IN_WIDTH-1:0]        in_has_wdata,
  input  logic [IN_WIDTH*XLEN-1:0]   in_wdata,
  input  logic [IN_WIDTH*3-1:0]      in_priv,
  output logic [63:0]                cycle,
  output logic                       trace_0_valid,
  output logic                       trace_0_exception,
  output logic                       trace_0_interrupt,
  output logic                       trace_0_has_wdata,
  output logic [XLEN-1:0]            trace_0_iaddr,
  output logic [XLEN-1:0]            trace_0_cause,
  output logic [XLEN-1:0]            trace_0_wdata,
  output logic [31:0]                trace_0_insn,
  output logic [2:0]                 trace_0_priv,
  output logic                       trace_1_valid,
  output logic                       trace_1_exception,
  output logic                       trace_1_interrupt,
  output logic                       trace_1_has_wdata,
  output logic [XLEN-1:0]            trace_1_iaddr,
  output logic [XLEN-1:0]            trace_1_cause,
  output logic [XLEN-1:0]            trace_1_wdata,
  output logic [31:0]                trace_1_insn,
  output logic [2:0]                 trace_1_priv,
  output logic [$clog2(DEPTH):0]     occupancy,
  output logic                       overflow_err
);

  localparam int unsigned PTR_W = $clog2(DEPTH) + 1;

  trace_rec_t       push_rec [IN_WIDTH];
  trace_rec_t       pop_rec  [2];
  trace_rec_t       stage_q  [2];
  trace_rec_t       stage_d  [2];
  trace_rec_t       lane_q   [2];
  logic [1:0]       pop_cnt;
  logic [PTR_W-1:0] occ;
  logic             offer;
  logic             push_en;
  logic             overflow_q, overflow_d;
  logic [63:0]      cnt_q, cycle_q;

  always_comb begin
    for (int unsigned i = 0; i < IN_WIDTH; i++) begin
      push_rec[i].commit    = in_commit[i];
      push_rec[i].exception = in_exception[i];
      push_rec[i].interrupt = in_interrupt[i];
      push_rec[i].iaddr     = in_iaddr[i*XLEN +: XLEN];
      push_rec[i].insn      = in_insn[i*32 +: 32];
      push_rec[i].cause     = in_cause[i*XLEN +: XLEN];
      push_rec[i].has_wdata = in_has_wdata[i];
      push_rec[i].wdata     = in_wdata[i*XLEN +: XLEN];
      push_rec[i].priv      = in_priv[i*3 +: 3];
    end
  end

  assign in_ready = (PTR_W'(DEPTH) - occ) >= PTR_W'(IN_WIDTH);
  assign offer    = |in_valid;
  assign push_en  = in_ready && offer;

  cosim_trace_fifo #(
    .IN_WIDTH (IN_WIDTH),
    .DEPTH    (DEPTH)
  ) u_fifo (
    .clock        (clock),
    .reset        (reset),
    .push_en_i    (push_en),
    .push_valid_i (in_valid),
    .push_rec_i   (push_rec),
    .pop_rec_o    (pop_rec),
    .pop_cnt_o    (pop_cnt),
    .occupancy_o  (occ)
  );

  // Popped records pass through one staging register before the lanes, so nothing
  // written at edge N can reach the monitor before edge N+2.
  always_comb begin
    stage_d[0] = (pop_cnt != 2'd0) ? pop_rec[0] : '0;
    stage_d[1] = (pop_cnt == 2'd2) ? pop_rec[1] : '0;
    overflow_d = overflow_q || (offer && !in_ready);
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      stage_q[0] <= '0;
      stage_q[1] <= '0;
      lane_q[0]  <= '0;
      lane_q[1]  <= '0;
      overflow_q <= 1'b0;
      cnt_q      <= '0;
      cycle_q    <= '0;
    end else begin
      stage_q    <= stage_d;
      lane_q     <= stage_q;
      overflow_q <= overflow_d;
      cnt_q      <= cnt_q + 64'd1;
      cycle_q    <= cnt_q;
    end
  end

  assign cycle        = cycle_q;
  assign occupancy    = occ;
  assign overflow_err = overflow_q;

  assign trace_0_valid     = lane_q[0].commit;
  assign trace_0_exception = lane_q[0].exception;
  assign trace_0_interrupt = lane_q[0].interrupt;
  assign trace_0_has_wdata = lane_q[0].has_wdata;
  assign trace_0_iaddr     = lane_q[0].iaddr;
  assign trace_0_cause     = lane_q[0].cause;
  assign trace_0_wdata     = lane_q[0].wdata;
  assign trace_0_insn      = lane_q[0].insn;
  assign trace_0_priv      = lane_q[0].priv;

  assign trace_1_valid     = lane_q[1].commit;
  assign trace_1_exception = lane_q[1].exception;
  assign trace_1_interrupt = lane_q[1].interrupt;
  assign trace_1_has_wdata = lane_q[1].has_wdata;
  assign trace_1_iaddr     = lane_q[1].iaddr;
  assign trace_1_cause     = lane_q[1].cause;
  assign trace_1_wdata     = lane_q[1].wdata;
  assign trace_1_insn      = lane_q[1].insn;
  assign trace_1_priv      = lane_q[1].priv;

endmodule

// File: tb/tb_cosim_trace_packer.sv
// Directed bench for cosim_trace_packer: per-cycle vector table plus backpressure and reset sequences.
module tb_cosim_trace_packer;

  logic         clock, reset;
  logic [3:0]   in_valid, in_commit, in_exception, in_interrupt, in_has_wdata;
  logic         in_ready;
  logic [255:0] in_iaddr, in_cause, in_wdata;
  logic [127:0] in_insn;
  logic [11:0]  in_priv;
  logic [63:0]  cycle;
  logic         trace_0_valid, trace_0_exception, trace_0_interrupt, trace_0_has_wdata;
  logic [63:0]  trace_0_iaddr, trace_0_cause, trace_0_wdata;
  logic [31:0]  trace_0_insn;
  logic [2:0]   trace_0_priv;
  logic         trace_1_valid, trace_1_exception, trace_1_interrupt, trace_1_has_wdata;
  logic [63:0]  trace_1_iaddr, trace_1_cause, trace_1_wdata;
  logic [31:0]  trace_1_insn;
  logic [2:0]   trace_1_priv;
  logic [4:0]   occupancy;
  logic         overflow_err;

  cosim_trace_packer #(.IN_WIDTH(4), .DEPTH(16), .XLEN(64)) dut (
    .clock(clock), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_commit(in_commit), .in_exception(in_exception), .in_interrupt(in_interrupt),
    .in_iaddr(in_iaddr), .in_insn(in_insn), .in_cause(in_cause),
    .in_has_wdata(in_has_wdata), .in_wdata(in_wdata), .in_priv(in_priv),
    .cycle(cycle),
    .trace_0_valid(trace_0_valid), .trace_0_exception(trace_0_exception),
    .trace_0_interrupt(trace_0_interrupt), .trace_0_has_wdata(trace_0_has_wdata),
    .trace_0_iaddr(trace_0_iaddr), .trace_0_cause(trace_0_cause),
    .trace_0_wdata(trace_0_wdata), .trace_0_insn(trace_0_insn), .trace_0_priv(trace_0_priv),
    .trace_1_valid(trace_1_valid), .trace_1_exception(trace_1_exception),
    .trace_1_interrupt(trace_1_interrupt), .trace_1_has_wdata(trace_1_has_wdata),
    .trace_1_iaddr(trace_1_iaddr), .trace_1_cause(trace_1_cause),
    .trace_1_wdata(trace_1_wdata), .trace_1_insn(trace_1_insn), .trace_1_priv(trace_1_priv),
    .occupancy(occupancy), .overflow_err(overflow_err)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int unsigned nvec = 0;
  int unsigned nerr = 0;

  typedef struct {
    logic [3:0]  v, c, e;
    logic [63:0] base;
    int unsigned occ;
    bit          p0, c0, e0;
    logic [63:0] pc0;
    bit          p1, c1, e1;
    logic [63:0] pc1;
  } vec_t;

  function automatic vec_t mk(logic [3:0] v, logic [3:0] c, logic [3:0] e, logic [63:0] base,
                              int unsigned occ,
                              bit p0, logic [63:0] pc0, bit c0, bit e0,
                              bit p1, logic [63:0] pc1, bit c1, bit e1);
    vec_t r;
    r.v = v; r.c = c; r.e = e; r.base = base; r.occ = occ;
    r.p0 = p0; r.pc0 = pc0; r.c0 = c0; r.e0 = e0;
    r.p1 = p1; r.pc1 = pc1; r.c1 = c1; r.e1 = e1;
    return r;
  endfunction

  // Every record field is derived from its PC so a lane can be checked from the PC alone.
  function automatic logic [230:0] lane_exp(bit pres, logic [63:0] pc, bit cm, bit ex);
    logic [230:0] r;
    if (!pres) r = '0;
    else r = {cm, ex, ex & pc[3], cm, pc, (ex ? {62'd0, pc[3:2]} : 64'd0),
              {pc[31:0], ~pc[31:0]}, {pc[15:0], 16'h0013}, pc[4:2]};
    return r;
  endfunction

  task automatic drive(logic [3:0] v, logic [3:0] c, logic [3:0] e, logic [63:0] base);
    logic [63:0] pc;
    in_valid = v; in_commit = c; in_exception = e; in_has_wdata = c;
    for (int l = 0; l < 4; l++) begin
      pc = base + 64'(4 * l);
      in_iaddr[l*64 +: 64] = pc;
      in_cause[l*64 +: 64] = e[l] ? {62'd0, pc[3:2]} : 64'd0;
      in_wdata[l*64 +: 64] = {pc[31:0], ~pc[31:0]};
      in_insn[l*32 +: 32]  = {pc[15:0], 16'h0013};
      in_priv[l*3 +: 3]    = pc[4:2];
      in_interrupt[l]      = e[l] & pc[3];
    end
  endtask

  task automatic idle();
    drive(4'b0000, 4'b0000, 4'b0000, 64'd0);
  endtask

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic check_lane(string nm, int k, bit pres, logic [63:0] pc, bit cm, bit ex);
    logic [230:0] act, exp;
    if (k == 0)
      act = {trace_0_valid, trace_0_exception, trace_0_interrupt, trace_0_has_wdata, trace_0_iaddr,
             trace_0_cause, trace_0_wdata, trace_0_insn, trace_0_priv};
    else
      act = {trace_1_valid, trace_1_exception, trace_1_interrupt, trace_1_has_wdata, trace_1_iaddr,
             trace_1_cause, trace_1_wdata, trace_1_insn, trace_1_priv};
    exp = lane_exp(pres, pc, cm, ex);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s lane%0d: got %h expected %h", nm, k, act, exp);
    end
  endtask

  logic [63:0] seen [$];
  bit          collect = 1'b0;

  always @(negedge clock) begin
    if (collect) begin
      if (trace_0_valid) seen.push_back(trace_0_iaddr);
      if (trace_1_valid) seen.push_back(trace_1_iaddr);
    end
  end

  vec_t tbl [19];

  initial begin
    int unsigned occm, popm, k;

    tbl[0]  = mk(4'h1, 4'h1, 4'h0, 64'h8000_0000, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    tbl[1]  = mk(4'h0, 4'h0, 4'h0, 64'h0,         0, 0, 0, 0, 0, 0, 0, 0, 0);
    tbl[2]  = mk(4'h0, 4'h0, 4'h0, 64'h0,         0, 1, 64'h8000_0000, 1, 0, 0, 0, 0, 0);
    tbl[3]  = mk(4'h0, 4'h0, 4'h0, 64'h0,         0, 0, 0, 0, 0, 0, 0, 0, 0);
    tbl[4]  = mk(4'hF, 4'hF, 4'h0, 64'h100,       4, 0, 0, 0, 0, 0, 0, 0, 0);
    tbl[5]  = mk(4'h0, 4'h0, 4'h0, 64'h0,         2, 0, 0, 0, 0, 0, 0, 0, 0);
    tbl[6]  = mk(4'h0, 4'h0, 4'h0, 64'h0,         0, 1, 64'h100, 1, 0, 1, 64'h104, 1, 0);
    tbl[7]  = mk(4'h0, 4'h0, 4'h0, 64'h0,         0, 1, 64'h108, 1, 0, 1, 64'h10C, 1, 0);
    tbl[8]  = mk(4'h0, 4'h0, 4'h0, 64'h0,         0, 0, 0, 0, 0, 0, 0, 0, 0);
    tbl[9]  = mk(4'h5, 4'h1, 4'h4, 64'h200,       2, 0, 0, 0, 0, 0, 0, 0, 0);
    tbl[10] = mk(4'h0, 4'h0, 4'h0, 64'h0,         0, 0, 0, 0, 0, 0, 0, 0, 0);
    tbl[11] = mk(4'h0, 4'h0, 4'h0, 64'h0,         0, 1, 64'h200, 1, 0, 1, 64'h208, 0, 1);
    tbl[12] = mk(4'h0, 4'h0, 4'h0, 64'h0,         0, 0, 0, 0, 0, 0, 0, 0, 0);
    tbl[13] = mk(4'h7, 4'h7, 4'h0, 64'h300,       3, 0, 0, 0, 0, 0, 0, 0, 0);
    tbl[14] = mk(4'hA, 4'hA, 4'h0, 64'h400,       3, 0, 0, 0, 0, 0, 0, 0, 0);
    tbl[15] = mk(4'h0, 4'h0, 4'h0, 64'h0,         1, 1, 64'h300, 1, 0, 1, 64'h304, 1, 0);
    tbl[16] = mk(4'h0, 4'h0, 4'h0, 64'h0,         0, 1, 64'h308, 1, 0, 1, 64'h404, 1, 0);
    tbl[17] = mk(4'h0, 4'h0, 4'h0, 64'h0,         0, 1, 64'h40C, 1, 0, 0, 0, 0, 0);
    tbl[18] = mk(4'h0, 4'h0, 4'h0, 64'h0,         0, 0, 0, 0, 0, 0, 0, 0, 0);

    // Reset held for three edges.
    reset = 1'b0;
    idle();
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      chk("rst_cycle", cycle, 64'd0);
      chk("rst_occ", 64'(occupancy), 64'd0);
      chk("rst_ready", 64'(in_ready), 64'd1);
      chk("rst_ovf", 64'(overflow_err), 64'd0);
      check_lane("rst", 0, 0, 0, 0, 0);
      check_lane("rst", 1, 0, 0, 0, 0);
    end
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      chk("cycle_count", cycle, 64'(i));
    end

    for (int i = 0; i < 19; i++) begin
      drive(tbl[i].v, tbl[i].c, tbl[i].e, tbl[i].base);
      @(negedge clock);
      chk($sformatf("vec%0d_occ", i), 64'(occupancy), 64'(tbl[i].occ));
      chk($sformatf("vec%0d_ready", i), 64'(in_ready), 64'd1);
      check_lane($sformatf("vec%0d", i), 0, tbl[i].p0, tbl[i].pc0, tbl[i].c0, tbl[i].e0);
      check_lane($sformatf("vec%0d", i), 1, tbl[i].p1, tbl[i].pc1, tbl[i].c1, tbl[i].e1);
    end

    // Backpressure: offer four lanes per cycle until the buffer nearly fills.
    collect = 1'b1;
    occm = 0;
    k = 0;
    while (occm < 13 && k < 10) begin
      chk("bp_ready_hi", 64'(in_ready), 64'd1);
      drive(4'hF, 4'hF, 4'h0, 64'h1000 + 64'(16 * k));
      @(negedge clock);
      popm = (occm >= 2) ? 2 : occm;
      occm = occm + 4 - popm;
      k++;
      chk("bp_occ", 64'(occupancy), 64'(occm));
    end
    chk("bp_offers", 64'(k), 64'd6);
    chk("bp_ready_lo", 64'(in_ready), 64'd0);
    chk("bp_ovf_before", 64'(overflow_err), 64'd0);
    drive(4'hF, 4'hF, 4'h0, 64'h1000 + 64'(16 * k));
    @(negedge clock);
    idle();
    chk("bp_occ_drop", 64'(occupancy), 64'd12);
    chk("bp_ovf_set", 64'(overflow_err), 64'd1);
    for (int i = 0; i < 10; i++) @(negedge clock);
    collect = 1'b0;
    chk("bp_occ_drained", 64'(occupancy), 64'd0);
    chk("bp_ovf_sticky", 64'(overflow_err), 64'd1);
    chk("bp_count", 64'(seen.size()), 64'd24);
    for (int i = 0; i < seen.size() && i < 24; i++)
      chk($sformatf("bp_order%0d", i), seen[i], 64'h1000 + 64'(4 * i));

    // Reset with eight records buffered.
    drive(4'hF, 4'hF, 4'h0, 64'h2000);
    @(negedge clock);
    drive(4'hF, 4'hF, 4'h0, 64'h2010);
    @(negedge clock);
    drive(4'hF, 4'hF, 4'h0, 64'h2020);
    @(negedge clock);
    idle();
    chk("r6_occ8", 64'(occupancy), 64'd8);
    reset = 1'b0;
    @(negedge clock);
    chk("r6_occ", 64'(occupancy), 64'd0);
    chk("r6_ovf", 64'(overflow_err), 64'd0);
    chk("r6_cycle", cycle, 64'd0);
    check_lane("r6", 0, 0, 0, 0, 0);
    check_lane("r6", 1, 0, 0, 0, 0);
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      chk("r6_post_cycle", cycle, 64'(i));
      chk("r6_post_occ", 64'(occupancy), 64'd0);
      check_lane("r6_post", 0, 0, 0, 0, 0);
      check_lane("r6_post", 1, 0, 0, 0, 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
